// File: rtl/sdram_arbiter.sv
// Two-client round-robin arbiter and transaction sequencer for the single
// sdram_top read/write request port, with an ack watchdog per transaction.
module sdram_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk_50m,
    input  logic        rst,

    input  logic        c0_req,
    input  logic        c0_we,
    input  logic [23:0] c0_addr,
    input  logic [8:0]  c0_len,
    input  logic [15:0] c0_wdata,
    output logic        c0_grant,
    output logic        c0_wack,
    output logic [15:0] c0_rdata,
    output logic        c0_rvalid,
    output logic        c0_done,
    output logic        c0_err,

    input  logic        c1_req,
    input  logic        c1_we,
    input  logic [23:0] c1_addr,
    input  logic [8:0]  c1_len,
    input  logic [15:0] c1_wdata,
    output logic        c1_grant,
    output logic        c1_wack,
    output logic [15:0] c1_rdata,
    output logic        c1_rvalid,
    output logic        c1_done,
    output logic        c1_err,

    input  logic        sdram_init_done,
    input  logic        sdram_busy,
    output logic [23:0] sdram_wr_addr,
    output logic [15:0] sdram_wr_data,
    output logic        sdram_wr_req,
    output logic [8:0]  sdwr_bytes,
    input  logic        sdram_wr_ack,
    output logic [23:0] sdram_rd_addr,
    output logic        sdram_rd_req,
    output logic [8:0]  sdrd_bytes,
    input  logic [15:0] sdram_rd_data,
    input  logic        sdram_rd_ack
);

    localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ISSUE,
        XFER,
        DONE
    } state_t;

    state_t          state;
    logic            last;
    logic            owner;
    logic            we_r;
    logic [8:0]      len_r;
    logic [8:0]      cnt;
    logic [WD_W-1:0] wd;

    logic       xfer_phase;
    logic       wr_hit;
    logic       rd_hit;
    logic       hit;
    logic [8:0] cnt_next;
    logic       pick;
    logic       any_req;
    logic       finish_ok;
    logic       timeout;

    assign xfer_phase = (state == ISSUE) || (state == XFER);
    // Acks only count in the direction of the latched command and only
    // while a transfer is actually outstanding.
    assign wr_hit     = xfer_phase &  we_r & sdram_wr_ack;
    assign rd_hit     = xfer_phase & ~we_r & sdram_rd_ack;
    assign hit        = wr_hit | rd_hit;
    assign cnt_next   = cnt + 9'd1;

    assign any_req = c0_req | c1_req;
    assign pick    = (c0_req & c1_req) ? ~last : c1_req;

    assign finish_ok = ((state == GRANT) && (len_r == 9'd0))
                     || (hit && (state == ISSUE) && (len_r == 9'd1))
                     || (hit && (state == XFER)  && (cnt_next == len_r));
    assign timeout   = xfer_phase & ~hit & (wd == WD_W'(TIMEOUT));

    assign c0_wack       = wr_hit & ~owner;
    assign c1_wack       = wr_hit &  owner;
    assign sdram_wr_data = owner ? c1_wdata : c0_wdata;

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state         <= IDLE;
            last          <= 1'b1;
            owner         <= 1'b0;
            we_r          <= 1'b0;
            len_r         <= '0;
            cnt           <= '0;
            wd            <= '0;
            c0_grant      <= 1'b0;
            c1_grant      <= 1'b0;
            c0_done       <= 1'b0;
            c1_done       <= 1'b0;
            c0_err        <= 1'b0;
            c1_err        <= 1'b0;
            c0_rvalid     <= 1'b0;
            c1_rvalid     <= 1'b0;
            c0_rdata      <= '0;
            c1_rdata      <= '0;
            sdram_wr_req  <= 1'b0;
            sdram_rd_req  <= 1'b0;
            sdram_wr_addr <= '0;
            sdram_rd_addr <= '0;
            sdwr_bytes    <= '0;
            sdrd_bytes    <= '0;
        end else begin
            c0_grant  <= 1'b0;
            c1_grant  <= 1'b0;
            c0_done   <= 1'b0;
            c1_done   <= 1'b0;
            c0_err    <= 1'b0;
            c1_err    <= 1'b0;
            c0_rvalid <= 1'b0;
            c1_rvalid <= 1'b0;

            if (rd_hit) begin
                if (owner) begin
                    c1_rdata  <= sdram_rd_data;
                    c1_rvalid <= 1'b1;
                end else begin
                    c0_rdata  <= sdram_rd_data;
                    c0_rvalid <= 1'b1;
                end
            end

            if (finish_ok || timeout) begin
                state        <= DONE;
                sdram_wr_req <= 1'b0;
                sdram_rd_req <= 1'b0;
                c0_done      <= ~owner;
                c1_done      <=  owner;
                c0_err       <= ~owner & timeout;
                c1_err       <=  owner & timeout;
                if (hit) begin
                    cnt <= (state == ISSUE) ? 9'd1 : cnt_next;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (sdram_init_done && !sdram_busy && any_req) begin
                            owner <= pick;
                            we_r  <= pick ? c1_we  : c0_we;
                            len_r <= pick ? c1_len : c0_len;
                            cnt   <= '0;
                            wd    <= '0;
                            c0_grant <= ~pick;
                            c1_grant <=  pick;
                            if (pick ? c1_we : c0_we) begin
                                sdram_wr_addr <= pick ? c1_addr : c0_addr;
                                sdwr_bytes    <= pick ? c1_len  : c0_len;
                            end else begin
                                sdram_rd_addr <= pick ? c1_addr : c0_addr;
                                sdrd_bytes    <= pick ? c1_len  : c0_len;
                            end
                            state <= GRANT;
                        end
                    end
                    GRANT: begin
                        sdram_wr_req <=  we_r;
                        sdram_rd_req <= ~we_r;
                        state        <= ISSUE;
                    end
                    ISSUE: begin
                        if (hit) begin
                            sdram_wr_req <= 1'b0;
                            sdram_rd_req <= 1'b0;
                            cnt          <= 9'd1;
                            wd           <= '0;
                            state        <= XFER;
                        end else begin
                            wd <= wd + WD_W'(1);
                        end
                    end
                    XFER: begin
                        if (hit) begin
                            cnt <= cnt_next;
                            wd  <= '0;
                        end else begin
                            wd <= wd + WD_W'(1);
                        end
                    end
                    DONE: begin
                        last  <= owner;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
